// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, op encoding and width helper for param_fifo
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 1;
    localparam int FIFO_DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_PUSHPOP
    } fifo_op_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int fifo_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - modulo-DEPTH pointer register with increment and synchronous clear
module fifo_ptr #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr,
    output logic [PW-1:0] ptr_next
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit wrap so non-power-of-two depths never visit unused slots.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr      = ptr_q;
    assign ptr_next = ptr_d;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised show-ahead FIFO with count, flags and error pulses
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int CW      = fifo_count_w(DEPTH),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [PW-1:0]    rd_ptr, rd_next;
    logic [PW-1:0]    wr_ptr, wr_next;
    logic             pop_ok, push_ok;
    logic [CW-1:0]    post_pop_cnt;

    always_comb begin
        pop_ok       = pop && (count_q != '0);
        post_pop_cnt = count_q - CW'(pop_ok);
        push_ok      = push && !clear && (post_pop_cnt < CW'(DEPTH));
        underflow_d  = pop && (count_q == '0);
        overflow_d   = push && !clear && (post_pop_cnt >= CW'(DEPTH));
        count_d      = clear ? '0 : post_pop_cnt + CW'(push_ok);
        // New head may be the word written on this very edge (push into an emptied FIFO).
        dout_d = '0;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr == rd_next)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_next];
            end
        end
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .inc      (pop_ok),
        .ptr      (rd_ptr),
        .ptr_next (rd_next)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .inc      (push_ok),
        .ptr      (wr_ptr),
        .ptr_next (wr_next)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    logic unused_ptr;
    assign unused_ptr  = ^{rd_ptr, wr_next};

    assign dout        = dout_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - directed self-checking bench for param_fifo (WIDTH=8, DEPTH=5, AF_LEVEL=4)
module tb_param_fifo;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int CW = fifo_count_w(D);

    logic          clk;
    logic          rst_n;
    logic          push, pop, clear;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic [CW-1:0] count;
    logic          empty, full, almost_full, overflow, underflow;

    int n_vec;
    int n_err;

    param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .clear       (clear),
        .din         (din),
        .dout        (dout),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int dv,
                           input bit e, input bit f, input bit af, input bit ov, input bit un);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".dout"}, 32'(dout), 32'(dv));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    task automatic step(input logic pu, input logic po, input logic cl, input logic [W-1:0] d);
        push  = pu;
        pop   = po;
        clear = cl;
        din   = d;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        logic [W-1:0] drain_exp [5];
        fifo_op_t     op;
        n_vec = 0;
        n_err = 0;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        din   = '0;
        rst_n = 1'b0;
        op    = OP_NONE;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // 1: fill
        op = OP_PUSH;
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, W'(i * 17));
            chk_all("fill", i, 8'h11, 0, i == 5, i >= 4, 0, 0);
        end

        // 2: overflow, then push+pop while full, then drain
        step(1, 0, 0, 8'h66);
        chk_all("ovf", 5, 8'h11, 0, 1, 1, 1, 0);
        op = OP_PUSHPOP;
        step(1, 1, 0, 8'h77);
        chk_all("full_pp", 5, 8'h22, 0, 1, 1, 0, 0);
        drain_exp[0] = 8'h22;
        drain_exp[1] = 8'h33;
        drain_exp[2] = 8'h44;
        drain_exp[3] = 8'h55;
        drain_exp[4] = 8'h77;
        op = OP_POP;
        for (int i = 0; i < 5; i++) begin
            chk("drain.head", 32'(dout), 32'(drain_exp[i]));
            step(0, 1, 0, '0);
        end
        chk_all("drained", 0, 0, 1, 0, 0, 0, 0);

        // 3: underflow, then push+pop while empty
        step(0, 1, 0, '0);
        chk_all("udf", 0, 0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 8'hA5);
        chk_all("empty_pp", 1, 8'hA5, 0, 0, 0, 0, 1);
        step(0, 0, 0, '0);
        chk_all("pulse_clr", 1, 8'hA5, 0, 0, 0, 0, 0);
        step(0, 1, 0, '0);
        chk_all("empty_again", 0, 0, 1, 0, 0, 0, 0);

        // 4: wrap-around with counter data
        step(1, 0, 0, 8'd0);
        step(1, 0, 0, 8'd1);
        chk_all("wrap.prime", 2, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 12; i++) begin
            chk("wrap.head", 32'(dout), 32'(i - 2));
            step(1, 1, 0, W'(i));
            chk("wrap.count", 32'(count), 32'd2);
        end
        chk("wrap.tail10", 32'(dout), 32'd10);
        step(0, 1, 0, '0);
        chk("wrap.tail11", 32'(dout), 32'd11);
        step(0, 1, 0, '0);
        chk_all("wrap.done", 0, 0, 1, 0, 0, 0, 0);

        // 5: clear with pop and push in the same cycle
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(1, 0, 0, 8'h03);
        chk_all("pre_clear", 3, 8'h01, 0, 0, 0, 0, 0);
        step(1, 1, 1, 8'h99);
        chk_all("clear", 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 8'h42);
        chk_all("post_clear", 1, 8'h42, 0, 0, 0, 0, 0);
        step(0, 1, 0, '0);
        chk_all("post_clear_pop", 0, 0, 1, 0, 0, 0, 0);

        // 6: async reset between edges
        step(1, 0, 0, 8'hC1);
        step(1, 0, 0, 8'hC2);
        step(1, 0, 0, 8'hC3);
        chk_all("pre_rst", 3, 8'hC1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step(1, 0, 0, 8'h5A);
        chk_all("after_rst", 1, 8'h5A, 0, 0, 0, 0, 0);
        step(0, 1, 0, '0);
        chk_all("after_rst_pop", 0, 0, 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
